// File: rtl/l2_buf_ctrl_if.sv
// l2_buf_ctrl_if
// Bundles every signal between the L2 request front-end, the way-buffer
// block and l2_buf_ctrl. The only signals outside the bundle are clk and rst.
//
// Signals:
//   req_valid/req_ready/req_set/req_tag  two-requester request channel
//   rd_mem_en/look/set                   way-buffer load strobe and set index
//   tags_buf/states_buf                  flattened tag and state buffers (way i at i*W)
//   evict_way_buf/incr_evict_way_buf     round-robin eviction pointer and its advance pulse
//   res_valid/res_ready/res_*            per-request lookup result channel
//
// Modports:
//   master  front-end / buffer side (drives requests, buffers, res_ready)
//   slave   the controller
interface l2_buf_ctrl_if #(
  parameter int WAYS    = 8,
  parameter int WAY_W   = 3,
  parameter int TAG_W   = 20,
  parameter int SET_W   = 8,
  parameter int STATE_W = 3
);
  logic [1:0]              req_valid;
  logic [1:0]              req_ready;
  logic [2*SET_W-1:0]      req_set;
  logic [2*TAG_W-1:0]      req_tag;
  logic                    rd_mem_en;
  logic                    look;
  logic [SET_W-1:0]        set;
  logic [WAYS*TAG_W-1:0]   tags_buf;
  logic [WAYS*STATE_W-1:0] states_buf;
  logic [WAY_W-1:0]        evict_way_buf;
  logic                    incr_evict_way_buf;
  logic                    res_valid;
  logic                    res_ready;
  logic                    res_id;
  logic                    res_hit;
  logic [WAY_W-1:0]        res_way;
  logic                    res_evict;

  modport master (
    output req_valid, req_set, req_tag, tags_buf, states_buf, evict_way_buf, res_ready,
    input  req_ready, rd_mem_en, look, set, incr_evict_way_buf,
           res_valid, res_id, res_hit, res_way, res_evict
  );

  modport slave (
    input  req_valid, req_set, req_tag, tags_buf, states_buf, evict_way_buf, res_ready,
    output req_ready, rd_mem_en, look, set, incr_evict_way_buf,
           res_valid, res_id, res_hit, res_way, res_evict
  );
endinterface

// File: rtl/l2_buf_ctrl.sv
// l2_buf_ctrl
// Lookup sequencer and two-requester round-robin arbiter for the L2 per-set
// way buffers. A granted request strobes the buffer load for its set, the
// loaded tags/states are compared against the request tag, and on a miss a
// victim way is chosen (first INVALID way scanning from the eviction pointer,
// else the eviction pointer itself, which is then advanced). One result is
// returned per granted request and held until accepted.
//
// Ports:
//   clk  clock
//   rst  synchronous reset, active low
//   bus  l2_buf_ctrl_if.slave (request, way-buffer and result channels)
//
// Build option:
//   L2_BUF_CTRL_PARALLEL_VICTIM_EN  when defined, the victim is picked
//   combinationally in LOOKUP (no VICTIM state); otherwise VICTIM examines
//   one way per cycle. Both builds select the same victim.
module l2_buf_ctrl #(
  parameter int WAYS    = 8,
  parameter int WAY_W   = 3,
  parameter int TAG_W   = 20,
  parameter int SET_W   = 8,
  parameter int STATE_W = 3
) (
  input logic          clk,
  input logic          rst,
  l2_buf_ctrl_if.slave bus
);

  localparam int CNT_W = WAY_W + 1;

  typedef enum logic [2:0] {IDLE, READ, LOOKUP, VICTIM, RESULT} state_t;

  state_t            state_reg, state_next;
  logic              rr_last_reg, rr_last_next;   // requester granted last
  logic [SET_W-1:0]  set_reg, set_next;
  logic [TAG_W-1:0]  tag_reg, tag_next;
  logic              id_reg, id_next;
  logic              hit_reg, hit_next;
  logic [WAY_W-1:0]  way_reg, way_next;
  logic              evict_reg, evict_next;
  logic              incr_reg, incr_next;
  logic [WAY_W-1:0]  scan_reg, scan_next;         // way examined this VICTIM cycle
  logic [WAY_W-1:0]  ptr_reg, ptr_next;           // eviction pointer captured on LOOKUP exit
  logic [CNT_W-1:0]  cnt_reg, cnt_next;           // ways already examined

  logic [1:0]        req_ready_c;
  logic              grant_any;
  logic              grant_id;

  // Per-way decode of the loaded buffers.
  logic [WAYS-1:0]   way_valid;
  logic [WAYS-1:0]   way_match;

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      assign way_valid[gi] = (bus.states_buf[gi*STATE_W +: STATE_W] != '0);
      assign way_match[gi] = way_valid[gi] &&
                             (bus.tags_buf[gi*TAG_W +: TAG_W] == tag_reg);
    end
  endgenerate

  // Lowest matching way wins: scan downwards so the last write is the lowest.
  logic              any_hit;
  logic [WAY_W-1:0]  hit_way;

  always_comb begin
    any_hit = 1'b0;
    hit_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (way_match[i]) begin
        any_hit = 1'b1;
        hit_way = WAY_W'(i);
      end
    end
  end

`ifdef L2_BUF_CTRL_PARALLEL_VICTIM_EN
  // First INVALID way in rotated order from the eviction pointer. The
  // WAY_W-bit sum wraps modulo WAYS because WAYS is a power of two.
  logic              par_found;
  logic [WAY_W-1:0]  par_way;

  always_comb begin
    par_found = 1'b0;
    par_way   = bus.evict_way_buf;
    for (int j = WAYS - 1; j >= 0; j--) begin
      if (!way_valid[bus.evict_way_buf + WAY_W'(j)]) begin
        par_found = 1'b1;
        par_way   = bus.evict_way_buf + WAY_W'(j);
      end
    end
  end
`endif

  // With both requesters pending, the one not granted last wins.
  assign grant_any = |bus.req_valid;
  assign grant_id  = (bus.req_valid == 2'b11) ? ~rr_last_reg : bus.req_valid[1];

  always_comb begin
    state_next   = state_reg;
    rr_last_next = rr_last_reg;
    set_next     = set_reg;
    tag_next     = tag_reg;
    id_next      = id_reg;
    hit_next     = hit_reg;
    way_next     = way_reg;
    evict_next   = evict_reg;
    incr_next    = 1'b0;
    scan_next    = scan_reg;
    ptr_next     = ptr_reg;
    cnt_next     = cnt_reg;
    req_ready_c  = 2'b00;

    case (state_reg)
      IDLE: begin
        if (grant_any) begin
          req_ready_c[grant_id] = 1'b1;
          rr_last_next = grant_id;
          id_next      = grant_id;
          set_next     = grant_id ? bus.req_set[SET_W +: SET_W] : bus.req_set[0 +: SET_W];
          tag_next     = grant_id ? bus.req_tag[TAG_W +: TAG_W] : bus.req_tag[0 +: TAG_W];
          state_next   = READ;
        end
      end

      READ: begin
        state_next = LOOKUP;
      end

      LOOKUP: begin
        if (any_hit) begin
          hit_next   = 1'b1;
          way_next   = hit_way;
          evict_next = 1'b0;
          state_next = RESULT;
        end else begin
          hit_next = 1'b0;
`ifdef L2_BUF_CTRL_PARALLEL_VICTIM_EN
          way_next   = par_way;
          evict_next = ~par_found;
          incr_next  = ~par_found;
          state_next = RESULT;
`else
          scan_next  = bus.evict_way_buf;
          ptr_next   = bus.evict_way_buf;
          cnt_next   = '0;
          state_next = VICTIM;
`endif
        end
      end

      VICTIM: begin
        if (!way_valid[scan_reg]) begin
          way_next   = scan_reg;
          evict_next = 1'b0;
          state_next = RESULT;
        end else if (cnt_reg == CNT_W'(WAYS - 1)) begin
          // Every way holds a line: evict at the pointer and advance it.
          way_next   = ptr_reg;
          evict_next = 1'b1;
          incr_next  = 1'b1;
          state_next = RESULT;
        end else begin
          scan_next = scan_reg + 1'b1;
          cnt_next  = cnt_reg + 1'b1;
        end
      end

      RESULT: begin
        if (bus.res_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      rr_last_reg <= 1'b1;   // requester 0 wins the first contested grant
      set_reg     <= '0;
      tag_reg     <= '0;
      id_reg      <= 1'b0;
      hit_reg     <= 1'b0;
      way_reg     <= '0;
      evict_reg   <= 1'b0;
      incr_reg    <= 1'b0;
      scan_reg    <= '0;
      ptr_reg     <= '0;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      rr_last_reg <= rr_last_next;
      set_reg     <= set_next;
      tag_reg     <= tag_next;
      id_reg      <= id_next;
      hit_reg     <= hit_next;
      way_reg     <= way_next;
      evict_reg   <= evict_next;
      incr_reg    <= incr_next;
      scan_reg    <= scan_next;
      ptr_reg     <= ptr_next;
      cnt_reg     <= cnt_next;
    end
  end

  // The grant is combinational so the request is consumed at the IDLE edge;
  // it is masked while reset is held so every output reads 0 in reset.
  assign bus.req_ready          = rst ? req_ready_c : 2'b00;
  assign bus.rd_mem_en          = (state_reg == READ);
  assign bus.look               = (state_reg == READ);
  assign bus.set                = set_reg;
  assign bus.incr_evict_way_buf = incr_reg;
  assign bus.res_valid          = (state_reg == RESULT);
  assign bus.res_id             = id_reg;
  assign bus.res_hit            = hit_reg;
  assign bus.res_way            = way_reg;
  assign bus.res_evict          = evict_reg;

endmodule

// File: tb/tb_l2_buf_ctrl.sv
// tb_l2_buf_ctrl
// Randomised and directed bench for l2_buf_ctrl (WAYS=4). The reference model
// computes grant order, hit way, victim way, eviction flag, pointer advance
// and result latency directly from the lookup rules using plain arrays.
module tb_l2_buf_ctrl;
  localparam int WAYS    = 4;
  localparam int WAY_W   = 2;
  localparam int TAG_W   = 20;
  localparam int SET_W   = 8;
  localparam int STATE_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  l2_buf_ctrl_if #(.WAYS(WAYS), .WAY_W(WAY_W), .TAG_W(TAG_W), .SET_W(SET_W), .STATE_W(STATE_W)) bus ();

  l2_buf_ctrl #(.WAYS(WAYS), .WAY_W(WAY_W), .TAG_W(TAG_W), .SET_W(SET_W), .STATE_W(STATE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int txn   = 0;
  int last_grant = 1;   // model: requester 0 wins first after reset

  logic [TAG_W-1:0]   m_tag   [WAYS];
  logic [STATE_W-1:0] m_state [WAYS];
  logic [WAY_W-1:0]   m_ptr;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return 32'({bus.req_ready, bus.rd_mem_en, bus.look, bus.set, bus.incr_evict_way_buf,
                bus.res_valid, bus.res_id, bus.res_hit, bus.res_way, bus.res_evict});
  endfunction

  function automatic logic [31:0] res_vec();
    return 32'({bus.res_valid, bus.res_id, bus.res_hit, bus.res_way, bus.res_evict, bus.set});
  endfunction

  task automatic load_bufs();
    for (int i = 0; i < WAYS; i++) begin
      bus.tags_buf[i*TAG_W +: TAG_W]       = m_tag[i];
      bus.states_buf[i*STATE_W +: STATE_W] = m_state[i];
    end
    bus.evict_way_buf = m_ptr;
  endtask

  // Runs one request from a negedge to the negedge after its result handshake.
  task automatic do_req(input logic [1:0] mask,
                        input logic [SET_W-1:0] s0, input logic [SET_W-1:0] s1,
                        input logic [TAG_W-1:0] t0, input logic [TAG_W-1:0] t1,
                        input int hold, input bit keep_valid);
    int g, exp_hit, exp_way, exp_evict, exp_incr, exp_lat, k;
    int rd_cnt, rd_cyc, incr_cnt, lat;
    logic [SET_W-1:0] exp_set, set_at_rd;
    logic [TAG_W-1:0] exp_tag;
    logic [1:0] busy;
    logic [31:0] snap;
    bit seen, look_err, stable;

    // Reference model.
    g = (mask == 2'b11) ? 1 - last_grant : (mask[1] ? 1 : 0);
    last_grant = g;
    exp_set = g ? s1 : s0;
    exp_tag = g ? t1 : t0;
    exp_hit = 0; exp_way = 0; exp_evict = 0; exp_incr = 0; k = 0;
    for (int i = WAYS - 1; i >= 0; i--)
      if (m_state[i] != '0 && m_tag[i] == exp_tag) begin exp_hit = 1; exp_way = i; end
    if (exp_hit == 0) begin
      k = WAYS; exp_way = int'(m_ptr); exp_evict = 1; exp_incr = 1;
      for (int j = WAYS - 1; j >= 0; j--)
        if (m_state[(int'(m_ptr) + j) % WAYS] == '0) begin
          k = j + 1; exp_way = (int'(m_ptr) + j) % WAYS; exp_evict = 0; exp_incr = 0;
        end
    end
`ifdef L2_BUF_CTRL_PARALLEL_VICTIM_EN
    exp_lat = 3;
`else
    exp_lat = 3 + k;
`endif

    load_bufs();
    bus.req_set   = {s1, s0};
    bus.req_tag   = {t1, t0};
    bus.req_valid = mask;
    bus.res_ready = 1'b0;
    #1;
    check_val("grant", 32'(bus.req_ready), 32'(1 << g));

    rd_cnt = 0; rd_cyc = -1; incr_cnt = 0; lat = 0; seen = 0; look_err = 0;
    busy = 2'b00; set_at_rd = '0;
    for (int c = 1; c <= WAYS + 8 && !seen; c++) begin
      @(negedge clk);
      if (!keep_valid) bus.req_valid = 2'b00;
      #1;
      busy     |= bus.req_ready;
      look_err |= (bus.look != bus.rd_mem_en);
      if (bus.rd_mem_en) begin rd_cnt++; rd_cyc = c; set_at_rd = bus.set; end
      if (bus.incr_evict_way_buf) incr_cnt++;
      if (bus.res_valid) begin seen = 1; lat = c; end
    end
    check_val("rd_count", 32'(rd_cnt), 32'(1));
    check_val("rd_cycle", 32'(rd_cyc), 32'(1));
    check_val("rd_set", 32'(set_at_rd), 32'(exp_set));
    check_val("look_eq_rd", 32'(look_err), 32'(0));
    check_val("latency", 32'(lat), 32'(exp_lat));
    check_val("res_id", 32'(bus.res_id), 32'(g));
    check_val("res_hit", 32'(bus.res_hit), 32'(exp_hit));
    check_val("res_way", 32'(bus.res_way), 32'(exp_way));
    check_val("res_evict", 32'(bus.res_evict), 32'(exp_evict));

    snap = res_vec();
    stable = 1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1;
      if (res_vec() != snap || !bus.res_valid) stable = 0;
      busy |= bus.req_ready;
      if (bus.incr_evict_way_buf) incr_cnt++;
    end
    check_val("res_stable", 32'(stable), 32'(1));
    check_val("busy_ready", 32'(busy), 32'(0));
    check_val("incr_count", 32'(incr_cnt), 32'(exp_incr));

    $display("txn %0d: grant=%0d set=%0h tag=%0h hit=%0d way=%0d evict=%0d incr=%0d lat=%0d hold=%0d",
             txn, g, exp_set, exp_tag, exp_hit, exp_way, exp_evict, exp_incr, exp_lat, hold);
    txn++;

    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int a, b;
    logic [TAG_W-1:0] t0, t1;

    bus.req_valid = 2'b00; bus.req_set = '0; bus.req_tag = '0;
    bus.tags_buf = '0; bus.states_buf = '0; bus.evict_way_buf = '0; bus.res_ready = 1'b0;
    for (int i = 0; i < WAYS; i++) begin m_tag[i] = '0; m_state[i] = '0; end
    m_ptr = '0;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_val("reset_outputs", out_vec(), 32'(0));
    rst = 1'b1;
    @(negedge clk);

    // Both requesters held valid: grants alternate 0,1,0,1.
    for (int i = 0; i < WAYS; i++) begin m_tag[i] = TAG_W'(32'h100 + i); m_state[i] = 3'd1; end
    m_ptr = 2'd0;
    for (int r = 0; r < 4; r++) do_req(2'b11, 8'h11, 8'h22, 20'h101, 20'h102, 0, 1'b1);
    bus.req_valid = 2'b00;

    // Hit in way 2.
    for (int i = 0; i < WAYS; i++) begin m_tag[i] = TAG_W'(32'h40 + i); m_state[i] = 3'd1; end
    m_tag[2] = 20'h1A; m_state[2] = 3'd2;
    do_req(2'b01, 8'd5, 8'd0, 20'h1A, 20'h0, 0, 1'b0);

    // Miss, states {1,1,0,1}, pointer 1: victim way 2, no eviction.
    m_state[0] = 3'd1; m_state[1] = 3'd1; m_state[2] = 3'd0; m_state[3] = 3'd1; m_ptr = 2'd1;
    do_req(2'b01, 8'd7, 8'd0, 20'h55, 20'h0, 0, 1'b0);

    // Miss, all ways valid, pointer 3: evict way 3 and advance the pointer.
    for (int i = 0; i < WAYS; i++) m_state[i] = 3'd3;
    m_ptr = 2'd3;
    do_req(2'b01, 8'd9, 8'd0, 20'h66, 20'h0, 0, 1'b0);

    // Result back-pressured for 10 cycles.
    m_tag[1] = 20'h777;
    do_req(2'b10, 8'd0, 8'h3C, 20'h0, 20'h777, 10, 1'b0);

    // Reset during the victim scan.
    for (int i = 0; i < WAYS; i++) begin m_tag[i] = TAG_W'(32'h10 + i); m_state[i] = 3'd3; end
    m_ptr = 2'd0;
    load_bufs();
    bus.req_set = {8'h00, 8'h21}; bus.req_tag = {20'h0, 20'h77}; bus.req_valid = 2'b01;
    @(negedge clk);
    bus.req_valid = 2'b00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check_val("mid_reset_outputs", out_vec(), 32'(0));
    rst = 1'b1;
    last_grant = 1;
    @(negedge clk);
    m_tag[3] = 20'hBEEF; m_state[3] = 3'd4;
    do_req(2'b01, 8'h42, 8'h00, 20'hBEEF, 20'h0, 0, 1'b0);

    // Randomised traffic.
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < WAYS; i++) begin
        m_tag[i]   = TAG_W'($urandom);
        m_state[i] = ($urandom_range(0, 3) == 0) ? 3'd0 : STATE_W'($urandom_range(1, 7));
      end
      m_ptr = WAY_W'($urandom_range(0, WAYS - 1));
      t0 = TAG_W'($urandom);
      t1 = TAG_W'($urandom);
      a = $urandom_range(0, WAYS - 1);
      b = $urandom_range(0, WAYS - 1);
      if ($urandom_range(0, 1) == 1) m_tag[a] = t0;
      if ($urandom_range(0, 1) == 1) m_tag[b] = t1;
      if ($urandom_range(0, 3) == 0) m_tag[WAYS - 1] = t0;
      do_req(2'($urandom_range(1, 3)), SET_W'($urandom), SET_W'($urandom), t0, t1,
             $urandom_range(0, 3), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
